// File: rtl/rv_pkg.sv
// Shared RISC-V definitions: branch funct3 codes, ALU opcodes, status bit
// positions and the branch-resolver state/debug types.
package rv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_AND = 2'd3;

  // Bit positions inside the {n,z,c,v} ALU status word.
  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [3:0] flags;
  } bru_dbg_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/response channels between decode, the branch resolver and PC select.
interface branch_resolve_unit_if #(
  parameter int N = 32
) ();

  // Both channels: a transfer happens on a rising clk edge where valid && ready.
  // A producer holds valid and its payload steady until that edge; ready may
  // change freely and never depends combinationally on valid.
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_funct3;
  logic [N-1:0] req_rs1;
  logic [N-1:0] req_rs2;
  logic [N-1:0] req_pc;
  logic [N-1:0] req_imm;

  logic         resp_valid;
  logic         resp_ready;
  logic         resp_taken;
  logic [N-1:0] resp_target;
  logic         resp_illegal;

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm, resp_ready,
    input  req_ready, resp_valid, resp_taken, resp_target, resp_illegal
  );

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm, resp_ready,
    output req_ready, resp_valid, resp_taken, resp_target, resp_illegal
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition from funct3 and the flags of rs1-rs2.
// The c flag is the borrow out of the subtraction (set when rs1 <u rs2).
module branch_cond_eval
  import rv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] status,
  output logic       taken,
  output logic       illegal
);

  logic lt;
  assign lt = status[ST_N] ^ status[ST_V];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = status[ST_Z];
      F3_BNE:  taken = !status[ST_Z];
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = status[ST_C];
      F3_BGEU: taken = !status[ST_C];
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Multi-cycle branch resolver: borrows the shared ALU for one subtraction,
// evaluates the condition from its flags and returns taken/target.
module branch_resolve_unit
  import rv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  branch_resolve_unit_if.slave    bus,
  output logic [N-1:0]            alu_a,
  output logic [N-1:0]            alu_b,
  output logic [1:0]              alu_opcode,
  input  logic [3:0]              alu_status,
  output bru_dbg_t                dbg
);

  state_t       state_q;
  logic [2:0]   funct3_q;
  logic [N-1:0] pc_q;
  logic [N-1:0] imm_q;
  logic [3:0]   flags_q;
  logic         req_ready_q;
  logic         resp_valid_q;
  logic         resp_taken_q;
  logic         resp_illegal_q;
  logic [N-1:0] resp_target_q;

  logic         cond_taken;
  logic         cond_illegal;

  branch_cond_eval u_cond (
    .funct3  (funct3_q),
    .status  (alu_status),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  // The operand registers are the ALU drive: loaded on accept, zeroed once
  // EXEC ends so the ALU sees idle inputs whenever we do not own it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      funct3_q       <= '0;
      pc_q           <= '0;
      imm_q          <= '0;
      flags_q        <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_opcode     <= ALU_ADD;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_taken_q   <= 1'b0;
      resp_illegal_q <= 1'b0;
      resp_target_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            funct3_q    <= bus.req_funct3;
            pc_q        <= bus.req_pc;
            imm_q       <= bus.req_imm;
            alu_a       <= bus.req_rs1;
            alu_b       <= bus.req_rs2;
            alu_opcode  <= ALU_SUB;
            req_ready_q <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          flags_q        <= alu_status;
          resp_taken_q   <= cond_taken;
          resp_illegal_q <= cond_illegal;
          resp_target_q  <= cond_taken ? (pc_q + imm_q) : (pc_q + N'(4));
          alu_a          <= '0;
          alu_b          <= '0;
          alu_opcode     <= ALU_ADD;
          resp_valid_q   <= 1'b1;
          state_q        <= RESP;
        end
        RESP: begin
          // req_ready only rises after the handshake edge, so a request
          // presented in the handshake cycle waits for the next IDLE cycle.
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          alu_a        <= '0;
          alu_b        <= '0;
          alu_opcode   <= ALU_ADD;
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_taken   = resp_taken_q;
  assign bus.resp_illegal = resp_illegal_q;
  assign bus.resp_target  = resp_target_q;

  assign dbg.state = state_q;
  assign dbg.flags = flags_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a behavioural ALU on its ALU port.
module tb_branch_resolve_unit;
  import rv_pkg::*;

  localparam int N = 32;

  logic         clk;
  logic         rstn;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [1:0]   alu_opcode;
  logic [3:0]   alu_status;
  bru_dbg_t     dbg;

  int tests_run;
  int tests_failed;

  branch_resolve_unit_if #(.N(N)) bus ();

  branch_resolve_unit #(.N(N)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_status (alu_status),
    .dbg        (dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference ALU ----------------
  logic [N:0]   alu_wide;
  logic [N-1:0] alu_res;
  always_comb begin
    alu_wide = '0;
    case (alu_opcode)
      2'd0:    alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      2'd1:    alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      2'd2:    alu_wide = {1'b0, alu_a | alu_b};
      default: alu_wide = {1'b0, alu_a & alu_b};
    endcase
    alu_res       = alu_wide[N-1:0];
    alu_status[3] = alu_res[N-1];
    alu_status[2] = (alu_res == '0);
    alu_status[1] = alu_wide[N];
    alu_status[0] = (alu_opcode == 2'd1) ? ((alu_a[N-1] != alu_b[N-1]) && (alu_res[N-1] != alu_a[N-1]))
                  : (alu_opcode == 2'd0) ? ((alu_a[N-1] == alu_b[N-1]) && (alu_res[N-1] != alu_a[N-1]))
                  : 1'b0;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int budget;
    budget = 0;
    while (bus.req_ready !== 1'b1 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 20) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
  endtask

  // Present one request, step through EXEC and RESP, checking every phase.
  task automatic run_branch(input string tag, input logic [2:0] f3,
                            input logic [N-1:0] rs1, input logic [N-1:0] rs2,
                            input logic [N-1:0] pc, input logic [N-1:0] imm,
                            input logic exp_taken, input logic [N-1:0] exp_target,
                            input logic exp_illegal);
    wait_ready();
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_rs1    = rs1;
    bus.req_rs2    = rs2;
    bus.req_pc     = pc;
    bus.req_imm    = imm;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check({tag, "_exec_state"},  32'(dbg.state), 32'(EXEC));
    check({tag, "_exec_ready"},  32'(bus.req_ready), 32'd0);
    check({tag, "_exec_valid"},  32'(bus.resp_valid), 32'd0);
    check({tag, "_exec_opcode"}, 32'(alu_opcode), 32'd1);
    check({tag, "_exec_a"},      alu_a, rs1);
    check({tag, "_exec_b"},      alu_b, rs2);
    @(posedge clk); #1;
    check({tag, "_resp_valid"},   32'(bus.resp_valid), 32'd1);
    check({tag, "_taken"},        32'(bus.resp_taken), 32'(exp_taken));
    check({tag, "_target"},       bus.resp_target, exp_target);
    check({tag, "_illegal"},      32'(bus.resp_illegal), 32'(exp_illegal));
    check({tag, "_resp_opcode"},  32'(alu_opcode), 32'd0);
    check({tag, "_resp_a"},       alu_a, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_valid"},   32'(bus.resp_valid), 32'd0);
    check({tag, "_done_ready"},   32'(bus.req_ready), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rstn           = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.req_pc     = '0;
    bus.req_imm    = '0;
    bus.resp_ready = 1'b1;

    #12;
    check("rst_state",   32'(dbg.state), 32'(IDLE));
    check("rst_ready",   32'(bus.req_ready), 32'd1);
    check("rst_valid",   32'(bus.resp_valid), 32'd0);
    check("rst_taken",   32'(bus.resp_taken), 32'd0);
    check("rst_illegal", 32'(bus.resp_illegal), 32'd0);
    check("rst_target",  bus.resp_target, 32'd0);
    check("rst_opcode",  32'(alu_opcode), 32'd0);
    check("rst_a",       alu_a, 32'd0);
    check("rst_b",       alu_b, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_branch("beq_eq",    F3_BEQ,  32'd5,        32'd5, 32'h100,      32'h20,       1'b1, 32'h120,  1'b0);
    run_branch("bne_eq",    F3_BNE,  32'd5,        32'd5, 32'h100,      32'h20,       1'b0, 32'h104,  1'b0);
    run_branch("blt_neg",   F3_BLT,  32'hFFFFFFFF, 32'd1, 32'h300,      32'h40,       1'b1, 32'h340,  1'b0);
    run_branch("bltu_big",  F3_BLTU, 32'hFFFFFFFF, 32'd1, 32'h300,      32'h40,       1'b0, 32'h304,  1'b0);
    run_branch("bge_ovf",   F3_BGE,  32'h80000000, 32'd1, 32'h200,      32'h10,       1'b0, 32'h204,  1'b0);
    run_branch("bgeu_big",  F3_BGEU, 32'h80000000, 32'd1, 32'h200,      32'h10,       1'b1, 32'h210,  1'b0);
    run_branch("ill_010",   3'b010,  32'd0,        32'd0, 32'h400,      32'h8,        1'b0, 32'h404,  1'b1);
    run_branch("ill_011",   3'b011,  32'd4,        32'd4, 32'h500,      32'h8,        1'b0, 32'h504,  1'b1);
    run_branch("beq_wrap",  F3_BEQ,  32'd7,        32'd7, 32'hFFFFFFFC, 32'd8,        1'b1, 32'h4,    1'b0);
    run_branch("bne_back",  F3_BNE,  32'd1,        32'd2, 32'h1000,     32'hFFFFFFF0, 1'b1, 32'hFF0,  1'b0);
    run_branch("bne_wrap4", F3_BNE,  32'd3,        32'd3, 32'hFFFFFFFC, 32'h40,       1'b0, 32'h0,    1'b0);

    // Backpressure: response held while a second request waits.
    bus.resp_ready = 1'b0;
    wait_ready();
    bus.req_valid  = 1'b1;
    bus.req_funct3 = F3_BLT;
    bus.req_rs1    = 32'd2;
    bus.req_rs2    = 32'd9;
    bus.req_pc     = 32'h80;
    bus.req_imm    = 32'h100;
    @(posedge clk); #1;
    bus.req_funct3 = F3_BGEU;
    bus.req_rs1    = 32'd9;
    bus.req_rs2    = 32'd2;
    bus.req_pc     = 32'h40;
    bus.req_imm    = 32'h8;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",  32'(bus.resp_valid), 32'd1);
      check("bp_taken",  32'(bus.resp_taken), 32'd1);
      check("bp_target", bus.resp_target, 32'h180);
      check("bp_ready",  32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_valid", 32'(bus.resp_valid), 32'd0);
    check("bp_hs_state", 32'(dbg.state), 32'(IDLE));
    check("bp_hs_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("bp2_state",  32'(dbg.state), 32'(EXEC));
    check("bp2_a",      alu_a, 32'd9);
    @(posedge clk); #1;
    check("bp2_taken",  32'(bus.resp_taken), 32'd1);
    check("bp2_target", bus.resp_target, 32'h48);
    @(posedge clk); #1;

    // Reset during EXEC drops the in-flight request.
    wait_ready();
    bus.req_valid  = 1'b1;
    bus.req_funct3 = F3_BEQ;
    bus.req_rs1    = 32'd1;
    bus.req_rs2    = 32'd1;
    bus.req_pc     = 32'h600;
    bus.req_imm    = 32'h20;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("mid_exec_state", 32'(dbg.state), 32'(EXEC));
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_valid",  32'(bus.resp_valid), 32'd0);
    check("mid_rst_ready",  32'(bus.req_ready), 32'd1);
    check("mid_rst_opcode", 32'(alu_opcode), 32'd0);
    check("mid_rst_state",  32'(dbg.state), 32'(IDLE));
    @(posedge clk); #3;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    run_branch("post_rst", F3_BLTU, 32'd1, 32'd2, 32'h700, 32'h30, 1'b1, 32'h730, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
